// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Drives per-register en/clr from hazard and dmem-wait events.
module pipe_hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdE,
  input  logic        MemToRegE,
  input  logic        BranchTakenE,
  input  logic        DmemReqM,
  input  logic        DmemReadyM,
  output logic        EnF,
  output logic        EnD,
  output logic        ClrD,
  output logic        EnE,
  output logic        ClrE,
  output logic        EnM,
  output logic        ClrM,
  output logic        EnW,
  output logic        ClrW,
  output logic        DmemAbort,
  output logic [31:0] StallCycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ABORT    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'(TIMEOUT_CYCLES - 2);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_abort;
  logic [31:0]       r_stall_cnt;

  logic w_memstall;
  logic w_loaduse;
  logic w_sel_rst;
  logic w_sel_abt;
  logic w_sel_ms;
  logic w_sel_br;
  logic w_sel_lu;

  assign w_memstall = (r_state != ABORT)
                    & DmemReqM & ~DmemReadyM;

  assign w_loaduse = MemToRegE & (RdE != 5'd0)
                   & ((RdE == Rs1D) | (RdE == Rs2D));

  // One-hot selects: reset > abort > memstall > branch > load-use
  assign w_sel_rst = ~rst_n;
  assign w_sel_abt = rst_n & (r_state == ABORT);
  assign w_sel_ms  = rst_n & w_memstall;
  assign w_sel_br  = rst_n & ~w_sel_abt & ~w_memstall
                   & BranchTakenE;
  assign w_sel_lu  = rst_n & ~w_sel_abt & ~w_memstall
                   & ~BranchTakenE & w_loaduse;

  // Zero-latency enable/clear decode
  always_comb begin
    EnF  = 1'b1;
    EnD  = 1'b1;
    EnE  = 1'b1;
    EnM  = 1'b1;
    EnW  = 1'b1;
    ClrD = 1'b0;
    ClrE = 1'b0;
    ClrM = 1'b0;
    ClrW = 1'b0;
    unique case (1'b1)
      w_sel_rst: begin
        ClrD = 1'b1;
        ClrE = 1'b1;
        ClrM = 1'b1;
        ClrW = 1'b1;
      end
      w_sel_abt: begin
        EnF  = 1'b0;
        ClrD = 1'b1;
        ClrE = 1'b1;
        ClrM = 1'b1;
        ClrW = 1'b1;
      end
      w_sel_ms: begin
        EnF  = 1'b0;
        EnD  = 1'b0;
        EnE  = 1'b0;
        EnM  = 1'b0;
        ClrW = 1'b1;
      end
      w_sel_br: begin
        ClrD = 1'b1;
        ClrE = 1'b1;
      end
      w_sel_lu: begin
        EnF  = 1'b0;
        EnD  = 1'b0;
        ClrE = 1'b1;
      end
      default: begin
        EnF  = 1'b1;
      end
    endcase
  end

  // Next-state logic for the dmem wait sequencer
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      RUN: begin
        if (w_memstall) w_next = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (!w_memstall)
          w_next = RUN;
        else if (r_wait_cnt == LP_LAST)
          w_next = ABORT;
      end
      ABORT: w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  // State, wait counter and registered abort pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_abort    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_abort <= (w_next == ABORT);
      if (r_state == RUN && w_memstall)
        r_wait_cnt <= '0;
      else if (r_state == MEM_WAIT && w_memstall)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Saturating count of fetch-stalled cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (!EnF && r_stall_cnt != 32'hFFFF_FFFF)
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign DmemAbort   = r_abort;
  assign StallCycles = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Control vector order: EnF EnD ClrD EnE ClrE EnM ClrM EnW ClrW.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  Rs1D, Rs2D, RdE;
  logic        MemToRegE, BranchTakenE;
  logic        DmemReqM, DmemReadyM;
  logic        EnF, EnD, ClrD, EnE, ClrE;
  logic        EnM, ClrM, EnW, ClrW;
  logic        DmemAbort;
  logic [31:0] StallCycles;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] NORM = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] RSTV = 9'b1_1_1_1_1_1_1_1_1;
  localparam logic [8:0] LU   = 9'b0_0_0_1_1_1_0_1_0;
  localparam logic [8:0] BR   = 9'b1_1_1_1_1_1_0_1_0;
  localparam logic [8:0] MS   = 9'b0_0_0_0_0_0_0_1_1;
  localparam logic [8:0] AB   = 9'b0_1_1_1_1_1_1_1_1;

  pipe_hazard_ctrl #(
    .TIMEOUT_CYCLES(4),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .Rs1D(Rs1D),
    .Rs2D(Rs2D),
    .RdE(RdE),
    .MemToRegE(MemToRegE),
    .BranchTakenE(BranchTakenE),
    .DmemReqM(DmemReqM),
    .DmemReadyM(DmemReadyM),
    .EnF(EnF),
    .EnD(EnD),
    .ClrD(ClrD),
    .EnE(EnE),
    .ClrE(ClrE),
    .EnM(EnM),
    .ClrM(ClrM),
    .EnW(EnW),
    .ClrW(ClrW),
    .DmemAbort(DmemAbort),
    .StallCycles(StallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] ctl();
    return {EnF, EnD, ClrD, EnE, ClrE,
            EnM, ClrM, EnW, ClrW};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Rs1D         = 5'd0;
    Rs2D         = 5'd0;
    RdE          = 5'd0;
    MemToRegE    = 1'b0;
    BranchTakenE = 1'b0;
    DmemReqM     = 1'b0;
    DmemReadyM   = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #2;
    check("rst_ctl", ctl(), RSTV);
    check("rst_cnt", StallCycles, 0);
    check("rst_abt", DmemAbort, 0);
    #10 rst_n = 1'b1;
    cyc();
    check("run_ctl", ctl(), NORM);

    // load-use via Rs2
    MemToRegE = 1'b1; RdE = 5'd5;
    Rs2D = 5'd5; Rs1D = 5'd3;
    #1 check("lu_rs2", ctl(), LU);
    cyc();
    check("lu_cnt", StallCycles, 1);
    idle();
    #1 check("lu_off", ctl(), NORM);

    // RdE = x0 never stalls
    MemToRegE = 1'b1;
    #1 check("lu_x0", ctl(), NORM);
    cyc();
    check("lu_x0_cnt", StallCycles, 1);

    // load-use via Rs1
    RdE = 5'd7; Rs1D = 5'd7; Rs2D = 5'd1;
    #1 check("lu_rs1", ctl(), LU);
    cyc();
    check("lu_rs1_cnt", StallCycles, 2);

    // branch beats load-use
    BranchTakenE = 1'b1;
    #1 check("br_lu", ctl(), BR);
    cyc();
    check("br_cnt", StallCycles, 2);
    idle();

    // dmem 3 wait cycles, branch ignored meanwhile
    DmemReqM = 1'b1; BranchTakenE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("w3_ms%0d", i), ctl(), MS);
      cyc();
    end
    BranchTakenE = 1'b0; DmemReadyM = 1'b1;
    #1 check("w3_done", ctl(), NORM);
    check("w3_cnt", StallCycles, 5);
    cyc();
    check("w3_cnt2", StallCycles, 5);
    check("w3_abt", DmemAbort, 0);

    // zero-wait access
    #1 check("zw_ctl", ctl(), NORM);
    cyc();
    check("zw_cnt", StallCycles, 5);
    idle();

    // timeout with TIMEOUT_CYCLES = 4
    DmemReqM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("to_ms%0d", i), ctl(), MS);
      check($sformatf("to_abt%0d", i), DmemAbort, 0);
      cyc();
    end
    DmemReadyM = 1'b1;
    #1 check("abt_ctl", ctl(), AB);
    check("abt_pulse", DmemAbort, 1);
    check("abt_cnt0", StallCycles, 9);
    cyc();
    idle();
    #1 check("post_abt", ctl(), NORM);
    check("post_pulse", DmemAbort, 0);
    check("post_cnt", StallCycles, 10);

    // request dropped mid-wait behaves as ready
    DmemReqM = 1'b1;
    cyc();
    DmemReqM = 1'b0;
    #1 check("drop_ctl", ctl(), NORM);
    cyc();
    check("drop_cnt", StallCycles, 11);

    // reset asserted during MEM_WAIT
    DmemReqM = 1'b1;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1 check("mr_ctl", ctl(), RSTV);
    check("mr_cnt", StallCycles, 0);
    check("mr_abt", DmemAbort, 0);
    idle();
    #2 rst_n = 1'b1;
    cyc();
    check("mr_run", ctl(), NORM);
    cyc();
    check("mr_noabt", DmemAbort, 0);
    check("mr_cnt2", StallCycles, 0);

    // saturation
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.r_stall_cnt;
    MemToRegE = 1'b1; RdE = 5'd9; Rs1D = 5'd9;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("sat%0d", i), StallCycles,
            32'hFFFF_FFFF);
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
